// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction SRAM arbiter for fetch and loader
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

module imem_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ldr_mode_i,
    input  logic            f_req_i,
    input  logic [XLEN-1:0] f_addr_i,
    input  logic            f_flush_i,
    output logic            f_gnt_o,
    output logic            f_rvalid_o,
    output logic [XLEN-1:0] f_rdata_o,
    output logic            f_err_o,
    input  logic            l_req_i,
    input  logic            l_we_i,
    input  logic [XLEN-1:0] l_addr_i,
    input  logic [XLEN-1:0] l_wdata_i,
    output logic            l_gnt_o,
    output logic            l_rvalid_o,
    output logic            l_err_o,
    output logic [XLEN-1:0] l_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;
    typedef enum logic {LW_FETCH, LW_LOAD} winner_t;

    owner_t          owner_q, owner_d;
    winner_t         last_q, last_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic            f_cand, pick_load, any_gnt, addr_err;
    logic [XLEN-1:0] win_addr;

    // Loader wins when it is the only candidate or fetch won last time.
    assign f_cand    = f_req_i && !ldr_mode_i;
    assign pick_load = l_req_i && (!f_cand || last_q == LW_FETCH);
    assign any_gnt   = f_cand || l_req_i;
    assign f_gnt_o   = f_cand && !pick_load;
    assign l_gnt_o   = pick_load;
    assign win_addr  = pick_load ? l_addr_i : f_addr_i;

    // DEPTH is a power of two, so any set bit above the byte range is out of range.
    assign addr_err = (win_addr[1:0] != 2'b00) || (|win_addr[XLEN-1:AW+2]);

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (any_gnt && !addr_err) begin
            mem_en_o   = 1'b1;
            mem_addr_o = win_addr[AW+1:2];
            if (pick_load) begin
                mem_we_o    = l_we_i;
                mem_wdata_o = l_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            last_q  <= LW_LOAD;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        owner_d    = OWN_NONE;
        last_d     = last_q;
        err_d      = 1'b0;
        we_d       = 1'b0;
        f_rvalid_o = 1'b0;
        f_rdata_o  = '0;
        f_err_o    = 1'b0;
        l_rvalid_o = 1'b0;
        l_rdata_o  = '0;
        l_err_o    = 1'b0;

        if (f_gnt_o) begin
            owner_d = OWN_FETCH;
            last_d  = LW_FETCH;
            err_d   = addr_err;
        end else if (l_gnt_o) begin
            owner_d = OWN_LOAD;
            last_d  = LW_LOAD;
            err_d   = addr_err;
            we_d    = l_we_i;
        end

        // Responses belong to the previous cycle's winner.
        case (owner_q)
            OWN_FETCH: begin
                f_rvalid_o = !f_flush_i;
                f_rdata_o  = err_q ? '0 : mem_rdata_i;
                f_err_o    = err_q && !f_flush_i;
            end
            OWN_LOAD: begin
                l_rvalid_o = 1'b1;
                l_err_o    = err_q;
                l_rdata_o  = (err_q || we_q) ? '0 : mem_rdata_i;
            end
            default: ;
        endcase
    end

    assign busy_o = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed scoreboard bench for imem_arbiter
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ldr_mode, f_req, f_flush, l_req, l_we;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
    logic [31:0] f_rdata, l_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_en, mem_we, busy;
    logic [10:0] mem_addr;

    logic [31:0] sram [2048];
    bit          written [2048];
    logic [31:0] ref_mem [int];

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q [$];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.DEPTH(2048)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ldr_mode_i(ldr_mode),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_flush_i(f_flush),
        .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata), .f_err_o(f_err),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_err_o(l_err), .l_rdata_o(l_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // SRAM model preloaded with word[i] = 0x1000_0000 + i
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                sram[mem_addr]    <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? sram[mem_addr] : 32'h1000_0000 + 32'(mem_addr);
            end
        end
    end

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h1000_0000 + idx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic ldr, input logic fr, input logic [31:0] fa,
                         input logic lr, input logic lw, input logic [31:0] la,
                         input logic [31:0] lwd, input logic fl);
        ldr_mode = ldr; f_req = fr; f_addr = fa; l_req = lr;
        l_we = lw; l_addr = la; l_wdata = lwd; f_flush = fl;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_f_rvalid"}, 32'(f_rvalid), 0);
        chk({tag, "_f_rdata"}, f_rdata, 0);
        chk({tag, "_f_err"}, 32'(f_err), 0);
        chk({tag, "_l_rvalid"}, 32'(l_rvalid), 0);
        chk({tag, "_l_rdata"}, l_rdata, 0);
        chk({tag, "_l_err"}, 32'(l_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_f_gnt"}, 32'(f_gnt), 0);
        chk({tag, "_l_gnt"}, 32'(l_gnt), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic step(input string tag, input logic ldr, input logic fr, input logic [31:0] fa,
                        input logic lr, input logic lw, input logic [31:0] la,
                        input logic [31:0] lwd, input logic fl,
                        input logic efg, input logic elg);
        exp_t        e, n;
        logic [31:0] a;
        logic        exp_en, exp_we;
        @(posedge clk);
        #1;
        drive(ldr, fr, fa, lr, lw, la, lwd, fl);
        @(negedge clk);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{kind: 0, data: 32'h0, err: 1'b0};
        chk({tag, "_f_rvalid"}, 32'(f_rvalid), 32'(e.kind == 1 && !fl));
        chk({tag, "_f_rdata"}, f_rdata, (e.kind == 1) ? e.data : 32'h0);
        chk({tag, "_f_err"}, 32'(f_err), 32'(e.kind == 1 && e.err && !fl));
        chk({tag, "_l_rvalid"}, 32'(l_rvalid), 32'(e.kind == 2));
        chk({tag, "_l_rdata"}, l_rdata, (e.kind == 2) ? e.data : 32'h0);
        chk({tag, "_l_err"}, 32'(l_err), 32'(e.kind == 2 && e.err));
        chk({tag, "_busy"}, 32'(busy), 32'(e.kind != 0));
        chk({tag, "_f_gnt"}, 32'(f_gnt), 32'(efg));
        chk({tag, "_l_gnt"}, 32'(l_gnt), 32'(elg));

        n.kind = efg ? 1 : (elg ? 2 : 0);
        a      = efg ? fa : la;
        n.err  = (n.kind != 0) && ((a[1:0] != 2'b00) || (a >= 32'h2000));
        exp_en = (n.kind != 0) && !n.err;
        exp_we = exp_en && n.kind == 2 && lw;
        if (!exp_en || exp_we) n.data = 32'h0;
        else n.data = ref_rd(int'(a[12:2]));
        if (exp_we) ref_mem[int'(a[12:2])] = lwd;
        chk({tag, "_mem_en"}, 32'(mem_en), 32'(exp_en));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
        chk({tag, "_mem_addr"}, 32'(mem_addr), exp_en ? 32'(a[12:2]) : 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, (exp_en && n.kind == 2) ? lwd : 32'h0);
        exp_q.push_back(n);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_zero("first_cycle");

        // back-to-back fetches
        step("fetch0", 0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 0);
        step("fetch4", 0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 0);
        step("fetch8", 0, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0);
        step("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // loader write then fetch of the same word
        step("ldr_wr40", 0, 0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 1);
        step("fetch40", 0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0);

        // misaligned fetch, out-of-range loader read
        step("fetch_mis", 0, 1, 32'h6, 0, 0, 0, 0, 0, 1, 0);
        step("ldr_oor", 0, 0, 0, 1, 0, 32'h2000, 0, 0, 0, 1);

        // both requesting: fetch first since the loader won last
        for (int i = 0; i < 4; i++)
            step($sformatf("rr%0d", i), 0, 1, 32'h10, 1, 0, 32'h20, 0, 0, i % 2 == 0, i % 2 == 1);

        // loader-exclusive mode, then release
        for (int i = 0; i < 3; i++)
            step($sformatf("ldrmode%0d", i), 1, 1, 32'h10, 1, 0, 32'h24, 0, 0, 0, 1);
        step("ldrmode_off", 0, 1, 32'h14, 1, 0, 32'h24, 0, 0, 1, 0);

        // flush suppresses the returning fetch response
        step("fetch_fl", 0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 0);
        step("flush", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset in the response cycle drops the response
        step("fetch_rst", 0, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_zero("rst_resp");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_rst");
        step("post_rst_tie", 0, 1, 32'h4, 1, 0, 32'h8, 0, 0, 1, 0);
        step("drain3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port arbiter and sequencer for the core's word-addressed instruction memory. It shares one synchronous SRAM port between the instruction-fetch stage (read-only) and the program loader (read/write, used for boot and debug). It also enforces alignment and range checks, and returns tagged responses with fixed one-cycle latency. The block sits between the fetch stage and the loader on one side, and the instruction SRAM macro on the other.

## Interface
- DEPTH, 2048: memory depth in XLEN-bit words. Must be a power of two.
- AW, $clog2(DEPTH): word-index width (localparam). XLEN comes from riscv_pkg.
- clk_i  in  1  core clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- ldr_mode_i  in  1  loader-exclusive mode; fetch is never granted while high
- f_req_i  in  1  fetch request
- f_addr_i  in  XLEN  fetch byte address
- f_flush_i  in  1  discard any fetch response returning this cycle
- f_gnt_o  out  1  fetch request accepted this cycle
- f_rvalid_o  out  1  fetch response valid
- f_rdata_o  out  XLEN  fetch instruction word
- f_err_o  out  1  fetch response is an error (misaligned or out of range)
- l_req_i, l_we_i  in  1, 1  loader request, write enable
- l_addr_i, l_wdata_i  in  XLEN, XLEN  loader byte address, write data
- l_gnt_o, l_rvalid_o, l_err_o  out  1, 1, 1  loader grant, response valid, error
- l_rdata_o  out  XLEN  loader read data; 0 for writes and errors
- mem_en_o, mem_we_o  out  1, 1  SRAM enable, write enable
- mem_addr_o  out  AW  SRAM word index, taken from addr[AW+1:2]
- mem_wdata_o  out  XLEN  SRAM write data
- mem_rdata_i  in  XLEN  SRAM read data, valid the cycle after an enabled read
- busy_o  out  1  a response is outstanding this cycle

## Operation
- Grant is combinational from the requests and takes effect in the same cycle.
  - At most one grant per cycle.
  - The transaction completes when req and gnt are both high.
- Arbitration is round-robin using a last_winner register (FETCH/LOAD):
  - Only one requester: that requester wins.
  - Both requesting: the one that is not last_winner wins.
  - last_winner updates only on a grant.
- With ldr_mode_i high, f_gnt_o=0 and the loader always wins.
- Error check on the winner's address, applied before any memory access:
  - Error if addr[1:0]!=0 or addr>=DEPTH*4.
  - An errored request is still granted. mem_en_o stays 0 and the response carries err=1 with rdata=0.
- Memory drive in the grant cycle:
  - Accepted, non-error request: mem_en_o=1, mem_we_o=(winner is loader && l_we_i), and mem_addr_o/mem_wdata_o from the winner.
  - Fetch requests never write.
  - Idle cycles drive all mem_* outputs to 0.
- Response FSM holds an owner register: NONE → FETCH or LOAD on a grant; otherwise back to NONE.
  - Owner register is updated every cycle, so back-to-back grants keep it at FETCH/LOAD with no idle cycle between them.
  - A registered err flag accompanies the owner.
- Response outputs in the cycle after the grant:
  - Owner FETCH: f_rvalid_o=!f_flush_i, f_rdata_o=err?0:mem_rdata_i, f_err_o=err&&!f_flush_i.
  - Owner LOAD: l_rvalid_o=1, l_err_o=err, l_rdata_o=(err||write)?0:mem_rdata_i.
  - Write acknowledgements are also delivered through l_rvalid_o.
- Responses cannot be back-pressured; requesters must accept them.
- f_flush_i only suppresses a fetch response returning this cycle. A new fetch request in the same cycle is arbitrated normally.
- busy_o = (owner != NONE).

## Timing
- Latency: grant in cycle N, response in cycle N+1. Throughput is one transaction per cycle.
- Outputs during reset and in the first cycle after reset: all 0.
  - owner=NONE, err=0, last_winner=LOAD, so fetch wins the first tie.
- Reset asserted while a response is outstanding: the response is dropped and never delivered.
- Simultaneous grant and response in one cycle is normal pipelined operation.
  - The response refers to the previous cycle's winner.
  - The memory port is driven for the current cycle's winner.
- A loader write followed by a fetch of the same address: the fetch in cycle N+1 returns the new data, given the SRAM's read-after-write across cycles.
- ldr_mode_i toggling takes effect on the same cycle's grant. It does not affect a response already in flight.

## Test plan
- Reset, then fetch 0x0, 0x4, 0x8 back-to-back (SRAM preloaded with word[i]=0x1000_0000+i) -> f_rvalid_o in cycles 1, 2, 3 with 0x1000_0000, 0x1000_0001, 0x1000_0002; f_err_o=0.
- Both requesters held high for 4 cycles (fetch 0x10, loader read 0x20) -> grants alternate F, L, F, L; responses alternate the following cycle with the correct words.
- Loader writes 0xDEADBEEF to 0x40, then fetches 0x40 -> l_rvalid_o=1 with l_rdata_o=0; then f_rdata_o=0xDEADBEEF.
- Fetch 0x6 (misaligned), then loader reads 0x2000 (DEPTH*4=0x2000, out of range) -> both granted, mem_en_o=0, and the next cycle's rvalid=1 with err=1 and rdata=0.
- ldr_mode_i=1 with both requesting for 3 cycles -> f_gnt_o=0 throughout, l_gnt_o=1 each cycle. Drop ldr_mode_i -> fetch is granted next.
- Fetch granted, then f_flush_i=1 in the next cycle -> f_rvalid_o=0. Separately, assert rst_ni low in the response cycle -> no rvalid, and all outputs 0.
